// File: rtl/serial_frame_tx_pkg.sv
// Shared frame definitions for the serial frame transmitter and the downstream demux controller.
// SERIAL_FRAME_PARITY_EN adds the parity state; both ends of the link must be built with the same setting.
package serial_frame_tx_pkg;

  localparam int   PORT_W     = 2;
  localparam int   CNT_W      = 4;
  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_START,
    ST_PORT,
    ST_COUNT,
    ST_DATA
`ifdef SERIAL_FRAME_PARITY_EN
    ,
    ST_PARITY
`endif
  } tx_state_e;

  function automatic logic hdr_parity(input logic [PORT_W-1:0] port, input logic [CNT_W-1:0] cnt);
    return ^{port, cnt};
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of the current frame field.
// Advances only on the bit-rate strobe; a load wins over a decrement and it parks at zero.
module frame_bit_counter
  import serial_frame_tx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (ld_i) begin
        cnt_d = ld_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, port MSB-first, count MSB-first, payload LSB-first, one bit per clkEn.
// Request registered in 1 clk; requests while busy are dropped. SERIAL_FRAME_PARITY_EN appends an even-parity bit.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [PORT_W-1:0] portNum,
  input  logic [CNT_W-1:0]  numData,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);

  tx_state_e         state_q;
  logic [PORT_W-1:0] port_q;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] data_q;
  logic              ser_q;
  logic              busy_q;
  logic              done_q;

  logic              cnt_ld_d;
  logic [CNT_W-1:0]  cnt_val_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_zero;

  logic [$clog2(PORT_W)-1:0] port_idx;
  logic [$clog2(CNT_W)-1:0]  cnt_idx;
  logic [IDX_W-1:0]          data_idx;

  frame_bit_counter u_bit_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (clkEn),
    .ld_i    (cnt_ld_d),
    .ld_val_i(cnt_val_d),
    .cnt_o   (cnt_q),
    .zero_o  (cnt_zero)
  );

  // Counter holds the bits still to follow the one on the line, so the next bit index derives from it.
  assign port_idx = $clog2(PORT_W)'(cnt_q - 1'b1);
  assign cnt_idx  = $clog2(CNT_W)'(cnt_q - 1'b1);
  assign data_idx = IDX_W'(num_q - cnt_q);

  always_comb begin
    cnt_ld_d  = 1'b0;
    cnt_val_d = '0;
    unique case (state_q)
      ST_START: begin
        cnt_ld_d  = 1'b1;
        cnt_val_d = CNT_W'(PORT_W - 1);
      end
      ST_PORT: begin
        if (cnt_zero) begin
          cnt_ld_d  = 1'b1;
          cnt_val_d = CNT_W'(CNT_W - 1);
        end
      end
      ST_COUNT: begin
        if (cnt_zero && (num_q != '0)) begin
          cnt_ld_d  = 1'b1;
          cnt_val_d = num_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef SERIAL_FRAME_PARITY_EN
  logic [DATA_W-1:0] pay_mask;
  logic              parity_bit;

  always_comb begin
    pay_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pay_mask[i] = (i < int'(num_q));
    end
  end

  assign parity_bit = hdr_parity(port_q, num_q) ^ (^(data_q & pay_mask));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      num_q   <= '0;
      data_q  <= '0;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            port_q  <= portNum;
            num_q   <= numData;
            data_q  <= data;
            busy_q  <= 1'b1;
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (clkEn) begin
            ser_q   <= START_BIT;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (clkEn) begin
            ser_q   <= port_q[PORT_W-1];
            state_q <= ST_PORT;
          end
        end
        ST_PORT: begin
          if (clkEn) begin
            if (!cnt_zero) begin
              ser_q <= port_q[port_idx];
            end else begin
              ser_q   <= num_q[CNT_W-1];
              state_q <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (clkEn) begin
            if (!cnt_zero) begin
              ser_q <= num_q[cnt_idx];
            end else if (num_q != '0) begin
              ser_q   <= data_q[0];
              state_q <= ST_DATA;
            end else begin
`ifdef SERIAL_FRAME_PARITY_EN
              ser_q   <= parity_bit;
              state_q <= ST_PARITY;
`else
              ser_q   <= IDLE_LEVEL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
`endif
            end
          end
        end
        ST_DATA: begin
          if (clkEn) begin
            if (!cnt_zero) begin
              ser_q <= data_q[data_idx];
            end else begin
`ifdef SERIAL_FRAME_PARITY_EN
              ser_q   <= parity_bit;
              state_q <= ST_PARITY;
`else
              ser_q   <= IDLE_LEVEL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
`endif
            end
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        ST_PARITY: begin
          if (clkEn) begin
            ser_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign serOut = ser_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: expected frame bits are queued when a request is issued and
// popped as the line advances on each clkEn edge.
module tb_serial_frame_tx;

  localparam int DATA_W = 15;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              clkEn   = 1'b0;
  logic              start   = 1'b0;
  logic [1:0]        portNum = '0;
  logic [3:0]        numData = '0;
  logic [DATA_W-1:0] data    = '0;
  logic              serOut;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int div   = 4;
  int ph    = 0;
  int cyc   = 0;
  bit exp_q[$];

  int   nb, nd, fc, ec, fc2, ec2, nb2, nd2, k, saw_done;
  logic lb, lb2, bpre, en;

  serial_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .start  (start),
    .portNum(portNum),
    .numData(numData),
    .data   (data),
    .serOut (serOut),
    .busy   (busy),
    .done   (done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // clkEn strobe every `div` clocks, changed on the falling edge.
  initial forever begin
    @(negedge clk);
    if (div <= 1) begin
      clkEn = 1'b1;
    end else begin
      clkEn = (ph == div - 1);
      ph    = (ph + 1) % div;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] p, input logic [3:0] n, input logic [DATA_W-1:0] d);
    logic par;
    par = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 1; i >= 0; i--) begin
      exp_q.push_back(p[i]);
      par ^= p[i];
    end
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(n[i]);
      par ^= n[i];
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(d[i]);
      par ^= d[i];
    end
`ifdef SERIAL_FRAME_PARITY_EN
    exp_q.push_back(par);
`endif
  endtask

  task automatic issue(input logic [1:0] p, input logic [3:0] n, input logic [DATA_W-1:0] d);
    portNum = p;
    numData = n;
    data    = d;
    start   = 1'b1;
    push_frame(p, n, d);
  endtask

  // Follows one frame until busy falls; poke_at re-pulses start with altered inputs mid-frame.
  task automatic collect(input string tag, input int budget, input int poke_at,
                         output int nbits, output int ndone, output int first_cyc,
                         output int end_cyc, output logic lastbit);
    logic e, bp, sprev, expb;
    bit   fin;
    int   unstable;
    nbits = 0; ndone = 0; first_cyc = -1; end_cyc = -1; lastbit = 1'bx;
    fin = 1'b0; unstable = 0; bp = busy; sprev = serOut;
    for (int c = 0; c < budget && !fin; c++) begin
      @(posedge clk);
      e = clkEn;
      #1;
      start = (c == poke_at);
      if (c == poke_at) begin
        portNum = ~portNum;
        numData = 4'd9;
        data    = ~data;
      end
      if (done) ndone++;
      if (!e && (serOut !== sprev)) unstable++;
      if (e && bp && busy) begin
        if (first_cyc < 0) first_cyc = cyc;
        nbits++;
        lastbit = serOut;
        if (exp_q.size() > 0) begin
          expb = exp_q.pop_front();
          check($sformatf("%s_bit%0d", tag, nbits), serOut, expb);
        end
      end
      if (bp && !busy) begin
        end_cyc = cyc;
        fin     = 1'b1;
        check({tag, "_end_idle"}, serOut, 1);
        check({tag, "_end_done"}, done, 1);
      end
      bp    = busy;
      sprev = serOut;
    end
    if (!fin) check({tag, "_timeout_busy"}, busy, 0);
    check({tag, "_stable_between_strobes"}, unstable, 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serOut", serOut, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // port 2, three payload bits, slow strobe
    div = 4;
    issue(2'd2, 4'd3, 15'b101);
    collect("t1", 200, -1, nb, nd, fc, ec, lb);
    check("t1_len", nb, 10 + PAR);
    check("t1_done_count", nd, 1);
    check("t1_busy_periods", ec - fc, (10 + PAR) * div);
    check("t1_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("t1_done_single", done, 0);

    // empty payload: random data must not appear on the line
    issue(2'd3, 4'd0, 15'($urandom));
    collect("t2", 200, -1, nb, nd, fc, ec, lb);
    check("t2_len", nb, 7 + PAR);
    check("t2_done_count", nd, 1);
    check("t2_busy_periods", ec - fc, (7 + PAR) * div);
    check("t2_queue_empty", exp_q.size(), 0);

    // maximum payload at one bit per clock
    div = 1;
    repeat (2) @(posedge clk);
    #1;
    issue(2'd1, 4'd15, 15'h7FFF);
    collect("t3", 100, -1, nb, nd, fc, ec, lb);
    check("t3_len", nb, 22 + PAR);
    check("t3_busy_clks", ec - fc, 22 + PAR);
    check("t3_queue_empty", exp_q.size(), 0);

    // start re-pulsed mid-frame is ignored, then a back-to-back request on done
    div = 3;
    repeat (4) @(posedge clk);
    #1;
    issue(2'd1, 4'd6, 15'h02A5);
    collect("t4a", 200, 8, nb, nd, fc, ec, lb);
    check("t4a_len", nb, 13 + PAR);
    check("t4a_queue_empty", exp_q.size(), 0);
    check("t4a_done_now", done, 1);
    issue(2'd0, 4'd4, 15'h000C);
    collect("t4b", 200, -1, nb2, nd2, fc2, ec2, lb2);
    check("t4b_len", nb2, 11 + PAR);
    check("t4b_done_count", nd2, 1);
    check("t4b_gap_after_done", fc2 - ec, div);
    check("t4b_queue_empty", exp_q.size(), 0);

    // asynchronous reset while the count field is on the line
    div = 2;
    repeat (3) @(posedge clk);
    #1;
    issue(2'd2, 4'd9, 15'h01FF);
    k = 0;
    bpre = busy;
    for (int c = 0; c < 100 && k < 5; c++) begin
      @(posedge clk);
      en = clkEn;
      #1;
      start = 1'b0;
      if (en && bpre && busy) k++;
      bpre = busy;
    end
    check("t5_reached_count", k, 5);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_serOut", serOut, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    saw_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    rst = 1'b1;
    exp_q.delete();
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    check("t5_no_done", saw_done, 0);
    check("t5_idle_after_release", busy, 0);

    // fresh frame after reset; final bit is data[0]=1, or the parity bit (also 1) when enabled
    issue(2'd1, 4'd1, 15'h0001);
    collect("t6", 200, -1, nb, nd, fc, ec, lb);
    check("t6_len", nb, 8 + PAR);
    check("t6_done_count", nd, 1);
    check("t6_last_bit", lb, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
